// File: rtl/branch_pkg.sv
// ============================================================================
// Module  : branch_pkg
// Brief   : funct3 encodings, BHT counter type and index helper for branch_resolve_unit
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef logic [1:0] br_ctr_t;

  localparam br_ctr_t CTR_INIT_DEFAULT = 2'b01;

  // Word-aligned PC bits select the counter; depth is a power of two.
  function automatic logic [31:0] bht_index(input logic [63:0] pc, input int unsigned depth);
    logic [63:0] v_mask;
    v_mask = 64'(depth) - 64'd1;
    return 32'((pc >> 2) & v_mask);
  endfunction

endpackage

`default_nettype wire

// File: rtl/branch_cmp.sv
// ============================================================================
// Module  : branch_cmp
// Brief   : Combinational XLEN-wide branch condition evaluation and funct3 decode
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_cmp
  import branch_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      f3,
  output logic            taken,
  output logic            illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (f3)
      F3_BEQ:  taken = (rs1 == rs2);
      F3_BNE:  taken = (rs1 != rs2);
      F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
      F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
      F3_BLTU: taken = (rs1 <  rs2);
      F3_BGEU: taken = (rs1 >= rs2);
      default: illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/branch_resolve_unit.sv
// ============================================================================
// Module  : branch_resolve_unit
// Brief   : Registered branch resolution with redirect/mispredict, 2-bit BHT,
//           optional statistics counters enabled by BRANCH_STATS_EN
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BHT_DEPTH = 64,
  parameter br_ctr_t     CTR_INIT  = CTR_INIT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [2:0]      in_f3,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_pred_taken,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic [XLEN-1:0] out_redirect,
  output logic            out_mispredict,
  output logic            out_illegal,
  input  logic [XLEN-1:0] pq_pc,
  output logic            pq_taken,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispred
);

  localparam int unsigned     c_idx_w   = $clog2(BHT_DEPTH);
  localparam logic [XLEN-1:0] c_pc_step = XLEN'(4);

  logic              w_cmp_taken;
  logic              w_cmp_illegal;
  logic              w_accept;
  logic              w_train;
  logic [XLEN-1:0]   w_redirect;
  logic [c_idx_w-1:0] w_in_idx;
  logic [c_idx_w-1:0] w_pq_idx;

  logic              r_out_valid;
  logic              r_taken;
  logic [XLEN-1:0]   r_redirect;
  logic              r_mispredict;
  logic              r_illegal;
  logic [c_idx_w-1:0] r_idx;
  br_ctr_t           r_bht [BHT_DEPTH];

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .f3      (in_f3),
    .taken   (w_cmp_taken),
    .illegal (w_cmp_illegal)
  );

  assign in_ready   = ~r_out_valid | out_ready;
  assign w_accept   = in_valid & in_ready;
  assign w_train    = r_out_valid & out_ready & ~flush & ~r_illegal;
  assign w_redirect = w_cmp_taken ? (in_pc + in_imm) : (in_pc + c_pc_step);
  assign w_in_idx   = c_idx_w'(bht_index(64'(in_pc), BHT_DEPTH));
  assign w_pq_idx   = c_idx_w'(bht_index(64'(pq_pc), BHT_DEPTH));

  // Flush has priority over a same-cycle accept: the incoming branch is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_taken      <= 1'b0;
      r_redirect   <= '0;
      r_mispredict <= 1'b0;
      r_illegal    <= 1'b0;
      r_idx        <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid  <= 1'b1;
      r_taken      <= w_cmp_taken;
      r_redirect   <= w_redirect;
      r_mispredict <= ~w_cmp_illegal & (w_cmp_taken ^ in_pred_taken);
      r_illegal    <= w_cmp_illegal;
      r_idx        <= w_in_idx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(BHT_DEPTH); i++) begin
        r_bht[i] <= CTR_INIT;
      end
    end else if (w_train) begin
      if (r_taken) begin
        if (r_bht[r_idx] != 2'b11) r_bht[r_idx] <= r_bht[r_idx] + 2'd1;
      end else begin
        if (r_bht[r_idx] != 2'b00) r_bht[r_idx] <= r_bht[r_idx] - 2'd1;
      end
    end
  end

  // Read of the array is pre-update, so a same-cycle training write is not visible.
  assign pq_taken = r_bht[w_pq_idx][1];

  assign out_valid      = r_out_valid;
  assign out_taken      = r_taken;
  assign out_redirect   = r_redirect;
  assign out_mispredict = r_mispredict;
  assign out_illegal    = r_illegal;

`ifdef BRANCH_STATS_EN
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_mispred;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_branches <= '0;
      r_stat_mispred  <= '0;
    end else if (w_train) begin
      if (r_stat_branches != 32'hFFFF_FFFF) r_stat_branches <= r_stat_branches + 32'd1;
      if (r_mispredict && (r_stat_mispred != 32'hFFFF_FFFF)) r_stat_mispred <= r_stat_mispred + 32'd1;
    end
  end

  assign stat_branches = r_stat_branches;
  assign stat_mispred  = r_stat_mispred;
`else
  assign stat_branches = '0;
  assign stat_mispred  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
// ============================================================================
// Module  : tb_branch_resolve_unit
// Brief   : Directed + random self-checking bench for branch_resolve_unit
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_resolve_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [2:0]  in_f3;
  logic [31:0] in_imm;
  logic        in_pred_taken;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic        out_taken;
  logic [31:0] out_redirect;
  logic        out_mispredict;
  logic        out_illegal;
  logic [31:0] pq_pc;
  logic        pq_taken;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state, kept at transaction level.
  bit          m_valid;
  bit          m_data_known;
  bit          m_taken;
  bit          m_mis;
  bit          m_ill;
  logic [31:0] m_redir;
  int          m_idx;
  logic [1:0]  m_bht [64];
  longint      m_br;
  longint      m_mp;

  branch_resolve_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pc          (in_pc),
    .in_rs1         (in_rs1),
    .in_rs2         (in_rs2),
    .in_f3          (in_f3),
    .in_imm         (in_imm),
    .in_pred_taken  (in_pred_taken),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_taken      (out_taken),
    .out_redirect   (out_redirect),
    .out_mispredict (out_mispredict),
    .out_illegal    (out_illegal),
    .pq_pc          (pq_pc),
    .pq_taken       (pq_taken),
    .stat_branches  (stat_branches),
    .stat_mispred   (stat_mispred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_resolve(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                      output bit t, output bit ill);
    t   = 1'b0;
    ill = 1'b0;
    case (f3)
      3'd0: t = (a == b);
      3'd1: t = (a != b);
      3'd4: t = ($signed(a) <  $signed(b));
      3'd5: t = ($signed(a) >= $signed(b));
      3'd6: t = (a <  b);
      3'd7: t = (a >= b);
      default: ill = 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m_valid      = 1'b0;
    m_data_known = 1'b1;
    m_taken      = 1'b0;
    m_mis        = 1'b0;
    m_ill        = 1'b0;
    m_redir      = '0;
    m_idx        = 0;
    m_br         = 0;
    m_mp         = 0;
    for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
  endtask

  task automatic put(input bit v, input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                     input logic [2:0] f3, input logic [31:0] imm, input bit pred);
    in_valid      = v;
    in_pc         = pc;
    in_rs1        = a;
    in_rs2        = b;
    in_f3         = f3;
    in_imm        = imm;
    in_pred_taken = pred;
  endtask

  // One clock: check combinational outputs, advance the model, then check registered outputs.
  task automatic tick();
    bit exp_rdy, acc, train, t, ill;
    int qi;
    #1;
    exp_rdy = !m_valid || out_ready;
    if (rst_n) begin
      qi = int'((pq_pc >> 2) % 64);
      check("in_ready", in_ready, exp_rdy);
      check("pq_taken", pq_taken, m_bht[qi][1]);
    end
    if (!rst_n) begin
      model_reset();
    end else begin
      train = m_valid && out_ready && !flush && !m_ill;
      acc   = in_valid && exp_rdy && !flush;
      if (train) begin
        if (m_taken) m_bht[m_idx] = (m_bht[m_idx] == 2'd3) ? 2'd3 : m_bht[m_idx] + 2'd1;
        else         m_bht[m_idx] = (m_bht[m_idx] == 2'd0) ? 2'd0 : m_bht[m_idx] - 2'd1;
        m_br++;
        if (m_mis) m_mp++;
      end
      if (flush) begin
        m_valid      = 1'b0;
        m_data_known = 1'b0;
      end else if (acc) begin
        ref_resolve(in_f3, in_rs1, in_rs2, t, ill);
        m_valid      = 1'b1;
        m_data_known = 1'b1;
        m_taken      = t;
        m_ill        = ill;
        m_mis        = !ill && (t != in_pred_taken);
        m_redir      = t ? in_pc + in_imm : in_pc + 32'd4;
        m_idx        = int'((in_pc >> 2) % 64);
      end else if (out_ready) begin
        m_valid      = 1'b0;
        m_data_known = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check("out_valid", out_valid, m_valid);
    if (m_data_known) begin
      check("out_taken", out_taken, m_taken);
      check("out_redirect", out_redirect, m_redir);
      check("out_mispredict", out_mispredict, m_mis);
      check("out_illegal", out_illegal, m_ill);
    end
`ifdef BRANCH_STATS_EN
    check("stat_branches", stat_branches, m_br[31:0]);
    check("stat_mispred", stat_mispred, m_mp[31:0]);
`else
    check("stat_branches", stat_branches, 32'd0);
    check("stat_mispred", stat_mispred, 32'd0);
`endif
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    pq_pc     = '0;
    put(0, 0, 0, 0, 3'd0, 0, 0);
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state: every counter weakly not-taken.
    for (int i = 0; i < 4; i++) begin
      pq_pc = $urandom;
      #1;
      check("reset_pq_taken", pq_taken, 1'b0);
    end
    pq_pc = 32'h100;

    // BLT -1 < 1 taken, predicted not-taken.
    put(1, 32'h100, 32'hFFFF_FFFF, 32'd1, 3'b100, 32'h20, 0);
    tick();
    check("blt_taken", out_taken, 1'b1);
    check("blt_redirect", out_redirect, 32'h120);
    check("blt_mispredict", out_mispredict, 1'b1);

    // BLTU same operands: 0xFFFFFFFF is not below 1.
    put(1, 32'h100, 32'hFFFF_FFFF, 32'd1, 3'b110, 32'h20, 0);
    tick();
    check("bltu_taken", out_taken, 1'b0);
    check("bltu_redirect", out_redirect, 32'h104);

    put(1, 32'h100, 32'hFFFF_FFFF, 32'd1, 3'b010, 32'h20, 1);
    tick();
    check("f3_010_illegal", out_illegal, 1'b1);
    check("f3_010_mispredict", out_mispredict, 1'b0);
    put(0, 0, 0, 0, 3'd0, 0, 0);
    tick();
    tick();
    check("illegal_no_train", pq_taken, 1'b0);

    // Backpressure: held result stays put while in_valid is held.
    out_ready = 1'b0;
    put(1, 32'h200, 32'd7, 32'd7, 3'b000, 32'h40, 1);
    tick();
    put(1, 32'h204, 32'd3, 32'd9, 3'b001, 32'hFFFF_FFF0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_redirect", out_redirect, 32'h240);
    end
    out_ready = 1'b1;
    tick();
    put(0, 0, 0, 0, 3'd0, 0, 0);
    tick();
    tick();

    // Counter saturation at pc 0x40.
    pq_pc = 32'h40;
    put(1, 32'h40, 32'd5, 32'd5, 3'b000, 32'h10, 0);
    tick();
    tick();
    tick();
    put(0, 0, 0, 0, 3'd0, 0, 0);
    tick();
    check("sat_pq_taken", pq_taken, 1'b1);
    put(1, 32'h40, 32'd5, 32'd6, 3'b000, 32'h10, 1);
    tick();
    put(0, 0, 0, 0, 3'd0, 0, 0);
    tick();
    check("after_nt_pq_taken", pq_taken, 1'b1);

    // Flush with a concurrent accept and a held result ready to drain.
    pq_pc = 32'h80;
    put(1, 32'h80, 32'd1, 32'd1, 3'b000, 32'h8, 0);
    tick();
    put(1, 32'h80, 32'd2, 32'd2, 3'b000, 32'h8, 0);
    flush = 1'b1;
    tick();
    check("flush_out_valid", out_valid, 1'b0);
    flush = 1'b0;
    put(0, 0, 0, 0, 3'd0, 0, 0);
    tick();
    check("flush_no_train", pq_taken, 1'b0);

    // Randomized traffic, including one mid-operation reset.
    for (int n = 0; n < 400; n++) begin
      rst_n     = (n != 200);
      flush     = ($urandom % 16) == 0;
      out_ready = ($urandom % 4) != 0;
      in_valid  = ($urandom % 4) != 0;
      if (($urandom % 4) == 0) in_pc = $urandom & 32'hFFFF_FFFC;
      else                     in_pc = 32'h1000 + (($urandom % 8) << 2);
      in_rs1        = $urandom;
      in_rs2        = (($urandom % 4) == 0) ? in_rs1 : $urandom;
      in_f3         = 3'($urandom % 8);
      in_imm        = $urandom & 32'hFFFF_FFFE;
      in_pred_taken = $urandom % 2;
      pq_pc         = 32'h1000 + (($urandom % 8) << 2);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
